// File: rtl/ir_stall_cache_if.sv
// Fetch-to-decode instruction bus for the stall cache: stall/flush control,
// the fetched word, and the held word plus hold statistics going to decode.
interface ir_stall_cache_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] i_data;
  logic [WIDTH-1:0] o_data;
  logic             o_hold;
  logic [CNT_W-1:0] o_hold_cnt;
  logic             o_hold_sat;
  logic [CNT_W-1:0] o_hold_events;

  modport master (
    output stall, flush, i_data,
    input  o_data, o_hold, o_hold_cnt, o_hold_sat, o_hold_events
  );

  modport slave (
    input  stall, flush, i_data,
    output o_data, o_hold, o_hold_cnt, o_hold_sat, o_hold_events
  );
endinterface

// File: rtl/ir_stall_cache.sv
// Instruction-register stall cache: a delayed copy of stall freezes the word
// presented to decode, with saturating hold-length and wrapping episode counters.
module ir_stall_cache #(
  parameter int WIDTH = 16,
  parameter int LAT   = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  ir_stall_cache_if.slave  bus
);

  logic [LAT-1:0]   sr_q,    sr_d;
  logic [WIDTH-1:0] cache_q, cache_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] ev_q,    ev_d;
  logic             hold;
  logic             hold_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign hold = sr_q[LAT-1];

  // Counters are driven from the hold value of the coming cycle, so they
  // already read 1 (and the new event) during the first hold cycle.
  always_comb begin
    sr_d[0] = bus.stall;
    for (int k = 1; k < LAT; k++) begin
      sr_d[k] = sr_q[k-1];
    end
    hold_nxt = sr_d[LAT-1];
    cache_d  = hold ? cache_q : bus.i_data;
    cnt_d    = '0;
    if (hold_nxt) begin
      cnt_d = hold ? sat_inc(cnt_q) : CNT_W'(1);
    end
    ev_d = (hold_nxt && !hold) ? ev_q + CNT_W'(1) : ev_q;
    if (bus.flush) begin
      sr_d    = '0;
      cache_d = '0;
      cnt_d   = '0;
      ev_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q    <= '0;
      cache_q <= '0;
      cnt_q   <= '0;
      ev_q    <= '0;
    end else begin
      sr_q    <= sr_d;
      cache_q <= cache_d;
      cnt_q   <= cnt_d;
      ev_q    <= ev_d;
    end
  end

  assign bus.o_data        = hold ? cache_q : bus.i_data;
  assign bus.o_hold        = hold;
  assign bus.o_hold_cnt    = cnt_q;
  assign bus.o_hold_sat    = (cnt_q == {CNT_W{1'b1}});
  assign bus.o_hold_events = ev_q;

endmodule

// File: tb/tb_ir_stall_cache.sv
// Directed bench for ir_stall_cache: three instances cover LAT=2 default,
// LAT=1 with a 2-bit counter, and LAT=4 pulse spacing.
module tb_ir_stall_cache;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  ir_stall_cache_if #(.WIDTH(16), .CNT_W(8)) bus0 ();
  ir_stall_cache_if #(.WIDTH(16), .CNT_W(2)) bus1 ();
  ir_stall_cache_if #(.WIDTH(16), .CNT_W(8)) bus2 ();

  ir_stall_cache #(.WIDTH(16), .LAT(2), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  ir_stall_cache #(.WIDTH(16), .LAT(1), .CNT_W(2)) u1 (.clk(clk), .rst(rst), .bus(bus1));
  ir_stall_cache #(.WIDTH(16), .LAT(4), .CNT_W(8)) u2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        h;
    logic [15:0] d;
    bus0.stall = 0; bus0.flush = 0; bus0.i_data = 16'hABCD;
    bus1.stall = 0; bus1.flush = 0; bus1.i_data = 16'h0000;
    bus2.stall = 0; bus2.flush = 0; bus2.i_data = 16'h0000;
    rst = 0;
    #1 rst = 1;
    #2;
    chk("rst_hold",   64'(bus0.o_hold), 64'(1'b0));
    chk("rst_cnt",    64'(bus0.o_hold_cnt), 64'(8'd0));
    chk("rst_sat",    64'(bus0.o_hold_sat), 64'(1'b0));
    chk("rst_events", 64'(bus0.o_hold_events), 64'(8'd0));
    chk("rst_data",   64'(bus0.o_data), 64'(16'hABCD));
    tick(); tick();
    rst = 0;

    // LAT=2: stall in cycles 5-7 -> hold in 7-9, word of cycle 6 held
    for (int c = 0; c <= 12; c++) begin
      tick();
      bus0.i_data = 16'h0010 + 16'(c);
      bus0.stall  = (c >= 5 && c <= 7);
      #1;
      h = (c >= 7 && c <= 9);
      d = h ? 16'h0016 : 16'h0010 + 16'(c);
      chk("a_hold", 64'(bus0.o_hold), 64'(h));
      chk("a_data", 64'(bus0.o_data), 64'(d));
      chk("a_cnt",  64'(bus0.o_hold_cnt), h ? 64'(c - 6) : 64'(0));
    end
    chk("a_events", 64'(bus0.o_hold_events), 64'(8'd1));

    // Flush in the second hold cycle with stall still high
    for (int c = 0; c <= 3; c++) begin
      tick();
      bus0.i_data = 16'h0100 + 16'(c);
      bus0.stall  = 1'b1;
      bus0.flush  = (c == 3);
      #1;
    end
    chk("b_fl_hold",   64'(bus0.o_hold), 64'(1'b1));
    chk("b_fl_data",   64'(bus0.o_data), 64'(16'h0101));
    chk("b_fl_cnt",    64'(bus0.o_hold_cnt), 64'(8'd2));
    chk("b_fl_events", 64'(bus0.o_hold_events), 64'(8'd2));
    tick();
    bus0.flush = 0; bus0.stall = 0; bus0.i_data = 16'h0104;
    #1;
    chk("b_hold",   64'(bus0.o_hold), 64'(1'b0));
    chk("b_cnt",    64'(bus0.o_hold_cnt), 64'(8'd0));
    chk("b_events", 64'(bus0.o_hold_events), 64'(8'd0));
    chk("b_data",   64'(bus0.o_data), 64'(16'h0104));

    // Asynchronous reset in the middle of a hold
    for (int c = 0; c <= 3; c++) begin
      tick();
      bus0.i_data = 16'h0300 + 16'(c);
      bus0.stall  = 1'b1;
      #1;
    end
    chk("c_pre_hold", 64'(bus0.o_hold), 64'(1'b1));
    chk("c_pre_cnt",  64'(bus0.o_hold_cnt), 64'(8'd2));
    #2;
    rst = 1; bus0.stall = 0;
    #1;
    chk("c_hold",   64'(bus0.o_hold), 64'(1'b0));
    chk("c_cnt",    64'(bus0.o_hold_cnt), 64'(8'd0));
    chk("c_sat",    64'(bus0.o_hold_sat), 64'(1'b0));
    chk("c_events", 64'(bus0.o_hold_events), 64'(8'd0));
    chk("c_data",   64'(bus0.o_data), 64'(16'h0303));
    #1 rst = 0;
    for (int c = 4; c <= 7; c++) begin
      tick();
      bus0.stall = (c == 4);
      #1;
      chk("c_relat_hold", 64'(bus0.o_hold), 64'(c == 6));
    end
    chk("c_relat_events", 64'(bus0.o_hold_events), 64'(8'd1));

    // LAT=1, CNT_W=2: stall 6 cycles -> cnt 1,2,3,3,3,3
    for (int c = 0; c <= 7; c++) begin
      tick();
      bus1.stall = (c <= 5);
      #1;
      h = (c >= 1 && c <= 6);
      chk("d_hold", 64'(bus1.o_hold), 64'(h));
      chk("d_cnt",  64'(bus1.o_hold_cnt), h ? 64'((c > 3) ? 3 : c) : 64'(0));
      chk("d_sat",  64'(bus1.o_hold_sat), 64'(h && c >= 3));
    end
    chk("d_events", 64'(bus1.o_hold_events), 64'(2'd1));
    for (int e = 0; e < 4; e++) begin
      tick();
      bus1.stall = 1'b1;
      tick();
      bus1.stall = 1'b0;
      #1;
      chk("d_ep_hold",   64'(bus1.o_hold), 64'(1'b1));
      chk("d_ep_events", 64'(bus1.o_hold_events), 64'((e + 2) % 4));
    end

    // LAT=4: two one-cycle pulses with a one-cycle gap
    for (int c = 0; c <= 8; c++) begin
      tick();
      bus2.i_data = 16'h0200 + 16'(c);
      bus2.stall  = (c == 0 || c == 2);
      #1;
      h = (c == 4 || c == 6);
      d = h ? 16'h0200 + 16'(c - 1) : 16'h0200 + 16'(c);
      chk("e_hold", 64'(bus2.o_hold), 64'(h));
      chk("e_data", 64'(bus2.o_data), 64'(d));
    end
    chk("e_events", 64'(bus2.o_hold_events), 64'(8'd2));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
